bcd2bin_seq: RTL

//  Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3

---
 rtl/bcd_pkg.sv | 36 +++
 rtl/bcd2bin_seq_if.sv | 26 ++
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/bcd2bin_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the BCD-to-binary converter.
// Optional feature macro used by the converter: BCD2BIN_RANGE_CHECK_EN.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam int unsigned BCD_MAX_DIGIT  = 9;
    localparam int unsigned BCD_ADJ_THRESH = 8;
    localparam int unsigned BCD_ADJ_VAL    = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_e;

    // True when an n-bit result can hold every value of a digits-wide BCD input.
    function automatic bit result_fits(int unsigned n, int unsigned digits);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        if (n >= 64) begin
            return 1'b1;
        end
        return (64'd1 << n) >= p;
    endfunction

    // A BCD digit above 9 is not a decimal digit.
    function automatic logic digit_invalid(logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/busy/done handshake plus data for the BCD-to-binary converter.
interface bcd2bin_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned N      = 10
);

    logic                          start;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
    logic                          busy;
    logic                          done;
    logic [N-1:0]                  binary;
    logic                          err;

    modport master (
        output start, bcd_in,
        input  busy, done, binary, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, binary, err
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: x >= 8 ? x - 3 : x (4-bit, no borrow out).
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout_c
);

    // Subtract 3 from digits that reached 8 or more after the shift.
    always_comb begin
        dout_c = din;
        if (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            dout_c = din - BCD_DIGIT_W'(BCD_ADJ_VAL);
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock (reverse double-dabble).
// Optional invalid-digit check enabled by defining BCD2BIN_RANGE_CHECK_EN.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned N      = 10
)(
    input logic          clock,
    input logic          reset,
    bcd2bin_seq_if.slave bus
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + N;
    localparam int unsigned CNT_W = $clog2(N + 1);

    if (!result_fits(N, DIGITS)) begin : g_width_check
        $error("bcd2bin_seq: N too small to hold 10**DIGITS-1");
    end

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [SR_W-1:0]    sr_shift_c;
    logic [BCD_W-1:0]   digits_adj_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N-1:0]       binary_q, binary_d;

    assign sr_shift_c = sr_q >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din    (sr_shift_c[N + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .dout_c (digits_adj_c[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic in_bad_c;
    logic err_pend_q, err_pend_d;
    logic err_q, err_d;

    // Any input digit above 9 marks the conversion as invalid.
    always_comb begin
        in_bad_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            in_bad_c |= digit_invalid(bus.bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
        end
    end
`endif

    // Next-state, datapath and output logic.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        binary_d = binary_q;
`ifdef BCD2BIN_RANGE_CHECK_EN
        err_pend_d = err_pend_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sr_d    = {bus.bcd_in, {N{1'b0}}};
                    cnt_d   = CNT_W'(N);
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
`ifdef BCD2BIN_RANGE_CHECK_EN
                    err_pend_d = in_bad_c;
`endif
                end
            end
            S_SHIFT: begin
                sr_d  = {digits_adj_c, sr_shift_c[N-1:0]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    binary_d = sr_shift_c[N-1:0];
`ifdef BCD2BIN_RANGE_CHECK_EN
                    if (err_pend_q) begin
                        binary_d = '0;
                    end
                    err_d = err_pend_q;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            binary_q <= '0;
`ifdef BCD2BIN_RANGE_CHECK_EN
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            binary_q <= binary_d;
`ifdef BCD2BIN_RANGE_CHECK_EN
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.binary = binary_q;
`ifdef BCD2BIN_RANGE_CHECK_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;
`endif

endmodule
